// File: rtl/bsnn_spike_voter.sv
// ---------------------------------------------------------------------------
// bsnn_spike_voter
//
// Purpose:
//   Collects NUM_STEPS binary spike rows from the BSNN stream wrapper and
//   votes on a winning output class. Neurons are split into N_CLASSES equal
//   groups of G = N_NEURONS/N_CLASSES consecutive bits. Each accepted row
//   adds the popcount of every group to that class's accumulator. After the
//   last row, a sequential scan (one class per cycle) picks the class with
//   the highest count. Ties go to the lowest class index. The decision is
//   presented on a valid/ready output handshake.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   valid_in     upstream spike row valid
//   ready_in     high only while accumulating (row can be accepted)
//   spikes_in    N_NEURONS-wide spike row; class c owns bits [c*G +: G]
//   valid_out    decision valid (held until ready_out)
//   ready_out    downstream accepts the decision
//   class_id     winning class index
//   class_score  accumulated spike count of the winning class
// ---------------------------------------------------------------------------
module bsnn_spike_voter #(
    parameter int N_NEURONS = 256,
    parameter int N_CLASSES = 8,
    parameter int NUM_STEPS = 4,
    localparam int G        = N_NEURONS / N_CLASSES,
    localparam int SCORE_W  = $clog2(G * NUM_STEPS + 1),
    localparam int ID_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [N_NEURONS-1:0] spikes_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [ID_W-1:0]      class_id,
    output logic [SCORE_W-1:0]   class_score
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ARGMAX = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  acc_q [N_CLASSES];
    logic [SCORE_W-1:0]  acc_d [N_CLASSES];
    logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
    logic [ID_W-1:0]     scanIdx_q, scanIdx_d;
    logic [ID_W-1:0]     bestId_q, bestId_d;
    logic [SCORE_W-1:0]  bestScore_q, bestScore_d;
    logic                validOut_q, validOut_d;
    logic [ID_W-1:0]     classId_q, classId_d;
    logic [SCORE_W-1:0]  classScore_q, classScore_d;

    logic [SCORE_W-1:0]  classCount [N_CLASSES];
    logic [SCORE_W-1:0]  scanScore;
    logic                takeScan;
    logic [ID_W-1:0]     candId;
    logic [SCORE_W-1:0]  candScore;

    // Number of set bits in one class group. A group holds at most G spikes,
    // and G never exceeds the accumulator range, so SCORE_W bits are enough.
    function automatic logic [SCORE_W-1:0] popcount(input logic [G-1:0] bits);
        logic [SCORE_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < G; i++) begin
            sum = sum + SCORE_W'(bits[i]);
        end
        return sum;
    endfunction

    // Per-class spike counts of the row currently on the input bus. They are
    // only added to the accumulators on an accepting edge.
    always_comb begin
        for (int c = 0; c < N_CLASSES; c++) begin
            classCount[c] = popcount(spikes_in[c*G +: G]);
        end
    end

    // Argmax candidate for the class under the scan index. Class 0 always
    // seeds the running best. A later class only displaces it when strictly
    // larger, which makes the lowest index win any tie.
    always_comb begin
        scanScore = acc_q[scanIdx_q];
        takeScan  = (scanIdx_q == '0) || (scanScore > bestScore_q);
        candId    = takeScan ? scanIdx_q : bestId_q;
        candScore = takeScan ? scanScore : bestScore_q;
    end

    // Next-state logic for the voter FSM.
    // ACCUM adds one row per handshake and leaves for ARGMAX on the final
    // step. ARGMAX walks the classes one per cycle and, on the last class,
    // latches the winner straight into the output registers. OUTPUT holds
    // the decision until the consumer takes it, then clears the
    // accumulators for the next decision. Rows offered during ARGMAX or
    // OUTPUT are ignored because ready_in is low there.
    always_comb begin
        state_d      = state_q;
        stepCnt_d    = stepCnt_q;
        scanIdx_d    = scanIdx_q;
        bestId_d     = bestId_q;
        bestScore_d  = bestScore_q;
        validOut_d   = validOut_q;
        classId_d    = classId_q;
        classScore_d = classScore_q;
        for (int c = 0; c < N_CLASSES; c++) begin
            acc_d[c] = acc_q[c];
        end

        case (state_q)
            ACCUM: begin
                if (valid_in) begin
                    for (int c = 0; c < N_CLASSES; c++) begin
                        acc_d[c] = acc_q[c] + classCount[c];
                    end
                    if (stepCnt_q == LAST_STEP) begin
                        stepCnt_d = '0;
                        scanIdx_d = '0;
                        state_d   = ARGMAX;
                    end else begin
                        stepCnt_d = stepCnt_q + STEP_W'(1);
                    end
                end
            end

            ARGMAX: begin
                bestId_d    = candId;
                bestScore_d = candScore;
                if (scanIdx_q == LAST_IDX) begin
                    classId_d    = candId;
                    classScore_d = candScore;
                    validOut_d   = 1'b1;
                    scanIdx_d    = '0;
                    state_d      = OUTPUT;
                end else begin
                    scanIdx_d = scanIdx_q + ID_W'(1);
                end
            end

            OUTPUT: begin
                if (ready_out) begin
                    validOut_d = 1'b0;
                    stepCnt_d  = '0;
                    scanIdx_d  = '0;
                    state_d    = ACCUM;
                    for (int c = 0; c < N_CLASSES; c++) begin
                        acc_d[c] = '0;
                    end
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register. Reset wins over any handshake on the same edge and
    // throws away a partial accumulation or an unread decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            stepCnt_q    <= '0;
            scanIdx_q    <= '0;
            bestId_q     <= '0;
            bestScore_q  <= '0;
            validOut_q   <= 1'b0;
            classId_q    <= '0;
            classScore_q <= '0;
            for (int c = 0; c < N_CLASSES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            stepCnt_q    <= stepCnt_d;
            scanIdx_q    <= scanIdx_d;
            bestId_q     <= bestId_d;
            bestScore_q  <= bestScore_d;
            validOut_q   <= validOut_d;
            classId_q    <= classId_d;
            classScore_q <= classScore_d;
            for (int c = 0; c < N_CLASSES; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    // The input is ready only while accumulating. The decision outputs come
    // straight from registers.
    assign ready_in    = (state_q == ACCUM);
    assign valid_out   = validOut_q;
    assign class_id    = classId_q;
    assign class_score = classScore_q;

endmodule

// File: tb/tb_bsnn_spike_voter.sv
// ---------------------------------------------------------------------------
// tb_bsnn_spike_voter
//
// Purpose:
//   Self-checking bench for bsnn_spike_voter at its default parameters
//   (256 neurons, 8 classes, 4 steps, 32 neurons per class). It uses a
//   table of decision vectors, randomised decisions checked against a
//   popcount/argmax model, and hand-written sequences for output stalls
//   and mid-decision resets. Expected decisions are queued when the rows
//   are driven and popped when the DUT raises valid_out.
// ---------------------------------------------------------------------------
module tb_bsnn_spike_voter;

    localparam int N_NEURONS = 256;
    localparam int N_CLASSES = 8;
    localparam int NUM_STEPS = 4;
    localparam int G         = N_NEURONS / N_CLASSES;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic                 ready_in;
    logic [N_NEURONS-1:0] spikes_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [2:0]           class_id;
    logic [7:0]           class_score;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int id;
        int score;
    } exp_t;

    typedef struct {
        logic [N_NEURONS-1:0] rows [NUM_STEPS];
        int                   gap;
        int                   expId;
        int                   expScore;
    } vec_t;

    exp_t expQ [$];
    vec_t vecs [6];

    bsnn_spike_voter #(
        .N_NEURONS (N_NEURONS),
        .N_CLASSES (N_CLASSES),
        .NUM_STEPS (NUM_STEPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .spikes_in   (spikes_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .class_id    (class_id),
        .class_score (class_score)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Place a 32-bit pattern into the bit group owned by class c.
    function automatic logic [N_NEURONS-1:0] classBits(input int c, input logic [31:0] pat);
        logic [N_NEURONS-1:0] r;
        r = '0;
        r[c*G +: G] = pat;
        return r;
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one row after `gap` idle cycles that carry random garbage with
    // valid_in low, and return just after the accepting edge.
    task automatic sendRow(input logic [N_NEURONS-1:0] row, input int gap);
        int waitCnt;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            valid_in  = 1'b0;
            spikes_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        valid_in  = 1'b1;
        spikes_in = row;
        waitCnt   = 0;
        while (!ready_in && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!ready_in) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL row accept: ready_in stayed 0 for %0d cycles", waitCnt);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Drive all rows of a decision and queue its expected result.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int r = 0; r < NUM_STEPS; r++) begin
            if (r == NUM_STEPS - 1) begin
                e.id    = v.expId;
                e.score = v.expScore;
                expQ.push_back(e);
            end
            sendRow(v.rows[r], v.gap);
        end
    endtask

    // Wait for the decision, check latency and values against the queue,
    // optionally stall the consumer with valid_in held high, then take the
    // decision and check the return to accumulation.
    task automatic checkOutput(input string tag, input int stallCycles);
        int   cyc;
        int   sawReady;
        exp_t e;
        ready_out = (stallCycles == 0);
        cyc       = 0;
        sawReady  = 0;
        while (!valid_out && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready_in) sawReady = 1;
        end
        checkValue({tag, " latency"}, cyc, 8);
        checkValue({tag, " ready_in during scan"}, sawReady, 0);
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s scoreboard: no expected decision queued", tag);
            ready_out = 1'b1;
            return;
        end
        e = expQ.pop_front();
        checkValue({tag, " class_id"}, int'(class_id), e.id);
        checkValue({tag, " class_score"}, int'(class_score), e.score);
        for (int i = 0; i < stallCycles; i++) begin
            valid_in  = 1'b1;
            spikes_in = '1;
            @(posedge clk);
            #1;
            checkValue({tag, " stall valid_out"}, int'(valid_out), 1);
            checkValue({tag, " stall class_id"}, int'(class_id), e.id);
            checkValue({tag, " stall class_score"}, int'(class_score), e.score);
            checkValue({tag, " stall ready_in"}, int'(ready_in), 0);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        checkValue({tag, " valid_out after take"}, int'(valid_out), 0);
        checkValue({tag, " ready_in after take"}, int'(ready_in), 1);
    endtask

    // Independent model: count spikes per group over all rows, strict argmax.
    function automatic exp_t modelDecision(input vec_t v);
        exp_t                 e;
        int                   s;
        logic [N_NEURONS-1:0] row;
        e.id    = 0;
        e.score = -1;
        for (int c = 0; c < N_CLASSES; c++) begin
            s = 0;
            for (int r = 0; r < NUM_STEPS; r++) begin
                row = v.rows[r];
                s += $countones(row[c*G +: G]);
            end
            if (s > e.score) begin
                e.id    = c;
                e.score = s;
            end
        end
        return e;
    endfunction

    initial begin
        vec_t v;
        exp_t e;
        int   cyc;

        // Fixed decision table.
        for (int r = 0; r < NUM_STEPS; r++) begin
            vecs[0].rows[r] = '0;
            vecs[1].rows[r] = classBits(5, 32'hFFFF_FFFF);
            vecs[2].rows[r] = classBits(2, 32'h0000_03FF) | classBits(6, 32'h0000_03FF);
            vecs[3].rows[r] = '0;
            vecs[4].rows[r] = classBits(7, 32'h8000_0000);
            vecs[5].rows[r] = classBits(1, 32'h0000_001F) | classBits(0, 32'h0000_000F);
        end
        vecs[3].rows[0] = classBits(4, 32'hFFFF_FFFF);
        vecs[3].rows[1] = classBits(3, 32'hFFFF_FFFF);
        vecs[4].rows[0] = classBits(7, 32'h8000_0000) | classBits(0, 32'h0000_0007);
        vecs[0].gap = 0; vecs[0].expId = 0; vecs[0].expScore = 0;
        vecs[1].gap = 0; vecs[1].expId = 5; vecs[1].expScore = 128;
        vecs[2].gap = 1; vecs[2].expId = 2; vecs[2].expScore = 40;
        vecs[3].gap = 0; vecs[3].expId = 3; vecs[3].expScore = 32;
        vecs[4].gap = 2; vecs[4].expId = 7; vecs[4].expScore = 4;
        vecs[5].gap = 3; vecs[5].expId = 1; vecs[5].expScore = 20;

        // Reset state, while held and just after release.
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        spikes_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset valid_out", int'(valid_out), 0);
        checkValue("reset class_id", int'(class_id), 0);
        checkValue("reset class_score", int'(class_score), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkValue("post-reset ready_in", int'(ready_in), 1);
        checkValue("post-reset valid_out", int'(valid_out), 0);

        // Table-driven decisions.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), 0);
        end

        // Randomised decisions checked against the model.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < NUM_STEPS; r++) begin
                v.rows[r] = {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()} &
                            {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
            end
            v.gap      = i % 2;
            e          = modelDecision(v);
            v.expId    = e.id;
            v.expScore = e.score;
            applyStimulus(v);
            checkOutput($sformatf("rand%0d", i), 0);
        end

        // Consumer stall of 20 cycles with valid_in held high, then a clean
        // decision to show nothing leaked in.
        for (int r = 0; r < NUM_STEPS; r++) v.rows[r] = classBits(4, 32'hFFFF_FFFF);
        v.gap = 0; v.expId = 4; v.expScore = 128;
        applyStimulus(v);
        checkOutput("stall", 20);
        applyStimulus(vecs[2]);
        checkOutput("after-stall", 0);

        // Reset after two rows of class 3, then four rows of class 1.
        sendRow(classBits(3, 32'hFFFF_FFFF), 0);
        sendRow(classBits(3, 32'hFFFF_FFFF), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkValue("mid-accum reset ready_in", int'(ready_in), 1);
        checkValue("mid-accum reset valid_out", int'(valid_out), 0);
        for (int r = 0; r < NUM_STEPS; r++) v.rows[r] = classBits(1, 32'hFFFF_FFFF);
        v.gap = 0; v.expId = 1; v.expScore = 128;
        applyStimulus(v);
        checkOutput("mid-accum reset", 0);

        // Reset while a decision is waiting for the consumer.
        for (int r = 0; r < NUM_STEPS; r++) v.rows[r] = classBits(6, 32'hFFFF_FFFF);
        v.gap = 0; v.expId = 6; v.expScore = 128;
        ready_out = 1'b0;
        applyStimulus(v);
        cyc = 0;
        while (!valid_out && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkValue("pending latency", cyc, 8);
        checkValue("pending class_id", int'(class_id), 6);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ready_out = 1'b1;
        if (expQ.size() > 0) void'(expQ.pop_front());
        checkValue("pending reset valid_out", int'(valid_out), 0);
        checkValue("pending reset class_id", int'(class_id), 0);
        checkValue("pending reset class_score", int'(class_score), 0);
        checkValue("pending reset ready_in", int'(ready_in), 1);
        applyStimulus(vecs[4]);
        checkOutput("after pending reset", 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
